// File: rtl/shared_onchip_mem_arbiter.sv
// -----------------------------------------------------------------------------
// shared_onchip_mem_arbiter
// Round-robin arbiter that shares one single-port on-chip RAM among
// NUM_MASTERS cores. Each core sees an Avalon-MM-style slave port with
// waitrequest and pipelined readdatavalid. A core may hold the grant across
// several transfers with m_lock for atomic read-modify-write sequences.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   m_address           per-master word address, master i at [i*ADDR_W +: ADDR_W]
//   m_byteenable        per-master byte enables
//   m_read, m_write     per-master requests (write wins when both are set)
//   m_writedata         per-master write data
//   m_lock              keep the grant after this transfer
//   m_waitrequest       1 = request not accepted this cycle
//   m_readdata          shared read data, qualified by m_readdatavalid
//   m_readdatavalid     one-hot read return strobe
//   mem_*               single-port RAM interface (clken low only in reset)
//   mem_readdata        RAM read data, READ_LATENCY cycles after a read
// -----------------------------------------------------------------------------
module shared_onchip_mem_arbiter #(
    parameter int NUM_MASTERS  = 3,
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_address,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] m_byteenable,
    input  logic [NUM_MASTERS-1:0]          m_read,
    input  logic [NUM_MASTERS-1:0]          m_write,
    input  logic [NUM_MASTERS*DATA_W-1:0]   m_writedata,
    input  logic [NUM_MASTERS-1:0]          m_lock,
    output logic [NUM_MASTERS-1:0]          m_waitrequest,
    output logic [DATA_W-1:0]               m_readdata,
    output logic [NUM_MASTERS-1:0]          m_readdatavalid,
    output logic [ADDR_W-1:0]               mem_address,
    output logic [DATA_W/8-1:0]             mem_byteenable,
    output logic                            mem_chipselect,
    output logic                            mem_write,
    output logic [DATA_W-1:0]               mem_writedata,
    output logic                            mem_clken,
    input  logic [DATA_W-1:0]               mem_readdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [IDX_W-1:0]       rr_r;
    logic [IDX_W-1:0]       rr_nxt_s;
    logic [IDX_W-1:0]       owner_r;
    logic [IDX_W-1:0]       owner_nxt_s;
    logic [NUM_MASTERS-1:0] req_s;
    logic                   grant_s;
    logic [IDX_W-1:0]       gidx_s;
    logic [IDX_W-1:0]       cand_s;
    logic                   accept_rd_s;
    logic [NUM_MASTERS-1:0] gnt_onehot_s;
    logic [NUM_MASTERS-1:0] rdv_pipe_r [READ_LATENCY];

    // Successor of a master index, wrapping modulo NUM_MASTERS.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] res;
        if (idx == IDX_W'(NUM_MASTERS - 1)) begin
            res = {IDX_W{1'b0}};
        end else begin
            res = idx + {{(IDX_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    assign req_s = m_read | m_write;

    // Grant selection: owner only while locked, otherwise first requester from rr.
    always_comb begin
        grant_s = 1'b0;
        gidx_s  = {IDX_W{1'b0}};
        cand_s  = rr_r;
        if (state_r == ST_LOCKED) begin
            if (req_s[owner_r]) begin
                grant_s = 1'b1;
                gidx_s  = owner_r;
            end else begin
                grant_s = 1'b0;
            end
        end else begin
            for (int k = 0; k < NUM_MASTERS; k++) begin
                if (!grant_s && req_s[cand_s]) begin
                    grant_s = 1'b1;
                    gidx_s  = cand_s;
                end else begin
                    grant_s = grant_s;
                end
                cand_s = next_idx(cand_s);
            end
        end
        // Nothing may be accepted while reset is asserted.
        grant_s = grant_s & reset_n;
    end

    assign accept_rd_s  = grant_s & ~m_write[gidx_s];
    assign gnt_onehot_s = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << gidx_s;

    // Next-state logic for the arbitration FSM, round-robin pointer and lock owner.
    always_comb begin
        state_nxt_s = state_r;
        rr_nxt_s    = rr_r;
        owner_nxt_s = owner_r;
        case (state_r)
            ST_ARB: begin
                if (grant_s) begin
                    rr_nxt_s = next_idx(gidx_s);
                    if (m_lock[gidx_s]) begin
                        owner_nxt_s = gidx_s;
                        state_nxt_s = ST_LOCKED;
                    end else begin
                        state_nxt_s = ST_ARB;
                    end
                end else begin
                    state_nxt_s = ST_ARB;
                end
            end
            ST_LOCKED: begin
                // The owner releases the lock with its final unlocked transfer;
                // an idle owner keeps the memory indefinitely.
                if (grant_s && !m_lock[owner_r]) begin
                    state_nxt_s = ST_ARB;
                    rr_nxt_s    = next_idx(owner_r);
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s = ST_ARB;
            end
        endcase
    end

    // FSM, round-robin pointer and lock owner registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_ARB;
            rr_r    <= {IDX_W{1'b0}};
            owner_r <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            rr_r    <= rr_nxt_s;
            owner_r <= owner_nxt_s;
        end
    end

    // Master-side handshake and RAM command mux driven from the granted master.
    always_comb begin
        m_waitrequest  = {NUM_MASTERS{1'b1}};
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = m_address[int'(gidx_s)*ADDR_W +: ADDR_W];
        mem_byteenable = m_byteenable[int'(gidx_s)*BE_W +: BE_W];
        mem_writedata  = m_writedata[int'(gidx_s)*DATA_W +: DATA_W];
        if (grant_s) begin
            m_waitrequest[gidx_s] = 1'b0;
            mem_chipselect        = 1'b1;
            mem_write             = m_write[gidx_s];
        end else begin
            mem_chipselect = 1'b0;
        end
    end

    // Read-return shift register; each stage carries the one-hot requester id.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                rdv_pipe_r[k] <= {NUM_MASTERS{1'b0}};
            end
        end else begin
            rdv_pipe_r[0] <= accept_rd_s ? gnt_onehot_s : {NUM_MASTERS{1'b0}};
            for (int k = 1; k < READ_LATENCY; k++) begin
                rdv_pipe_r[k] <= rdv_pipe_r[k-1];
            end
        end
    end

    assign m_readdatavalid = rdv_pipe_r[READ_LATENCY-1];
    assign m_readdata      = mem_readdata;
    assign mem_clken       = reset_n;

endmodule

// File: tb/tb_shared_onchip_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_onchip_mem_arbiter
// Bench for shared_onchip_mem_arbiter: a behavioural RAM on the memory side,
// directed scenarios plus randomized traffic on the master side, and a
// transaction-level reference of grant order, lock ownership and memory data.
// -----------------------------------------------------------------------------
module tb_shared_onchip_mem_arbiter;

    localparam int NM = 3;
    localparam int AW = 13;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int RL = 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NM*AW-1:0] m_address;
    logic [NM*BW-1:0] m_byteenable;
    logic [NM-1:0]    m_read;
    logic [NM-1:0]    m_write;
    logic [NM*DW-1:0] m_writedata;
    logic [NM-1:0]    m_lock;
    logic [NM-1:0]    m_waitrequest;
    logic [DW-1:0]    m_readdata;
    logic [NM-1:0]    m_readdatavalid;
    logic [AW-1:0]    mem_address;
    logic [BW-1:0]    mem_byteenable;
    logic             mem_chipselect;
    logic             mem_write;
    logic [DW-1:0]    mem_writedata;
    logic             mem_clken;
    logic [DW-1:0]    mem_readdata;

    shared_onchip_mem_arbiter #(
        .NUM_MASTERS (NM),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .READ_LATENCY(RL)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m_address      (m_address),
        .m_byteenable   (m_byteenable),
        .m_read         (m_read),
        .m_write        (m_write),
        .m_writedata    (m_writedata),
        .m_lock         (m_lock),
        .m_waitrequest  (m_waitrequest),
        .m_readdata     (m_readdata),
        .m_readdatavalid(m_readdatavalid),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with RL cycles of read latency.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] ram_pipe [RL];

    function automatic logic [DW-1:0] ram_merge(input logic [DW-1:0] old_w,
                                                input logic [DW-1:0] new_w,
                                                input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < BW; b++) begin
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) ram[mem_address] <= ram_merge(ram[mem_address], mem_writedata, mem_byteenable);
            else           ram_pipe[0] <= ram[mem_address];
        end
        for (int k = 1; k < RL; k++) ram_pipe[k] <= ram_pipe[k-1];
    end
    assign mem_readdata = ram_pipe[RL-1];

    // Reference state
    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
        bit            known;
    } exp_t;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            rr_m    = 0;
    int            owner_m = 0;
    bit            locked_m = 1'b0;
    logic [DW-1:0] ref_mem [int];
    exp_t          exp_q [$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        rr_m     = 0;
        owner_m  = 0;
        locked_m = 1'b0;
        exp_q.delete();
    endtask

    function automatic int model_grant();
        logic [NM-1:0] req;
        req = m_read | m_write;
        if (locked_m) return req[owner_m] ? owner_m : -1;
        for (int k = 0; k < NM; k++) begin
            if (req[(rr_m + k) % NM]) return (rr_m + k) % NM;
        end
        return -1;
    endfunction

    task automatic idle_all();
        m_read  = '0;
        m_write = '0;
        m_lock  = '0;
    endtask

    task automatic set_m(input int i, input bit rd, input bit wr, input bit lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        m_read[i]                = rd;
        m_write[i]               = wr;
        m_lock[i]                = lk;
        m_address[i*AW +: AW]    = a;
        m_writedata[i*DW +: DW]  = d;
        m_byteenable[i*BW +: BW] = be;
    endtask

    // Called just after a falling edge with inputs driven; returns on the next falling edge.
    task automatic step();
        int            g;
        logic [NM-1:0] exp_wait;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [BW-1:0] be;
        logic [DW-1:0] mask;
        exp_t          e;
        #1;
        g = model_grant();
        exp_wait = '1;
        if (g >= 0) exp_wait[g] = 1'b0;
        check_eq("waitrequest", 64'(m_waitrequest), 64'(exp_wait));
        check_eq("chipselect", 64'(mem_chipselect), 64'(g >= 0));
        a  = '0;
        d  = '0;
        be = '0;
        if (g >= 0) begin
            a  = m_address[g*AW +: AW];
            d  = m_writedata[g*DW +: DW];
            be = m_byteenable[g*BW +: BW];
            check_eq("mem_address", 64'(mem_address), 64'(a));
            check_eq("mem_write", 64'(mem_write), 64'(m_write[g]));
            if (m_write[g]) begin
                check_eq("mem_writedata", 64'(mem_writedata), 64'(d));
                check_eq("mem_byteenable", 64'(mem_byteenable), 64'(be));
            end
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check_eq("readdatavalid", 64'(m_readdatavalid), 64'(1) << e.id);
            if (e.known) check_eq("readdata", 64'(m_readdata), 64'(e.data));
        end else begin
            check_eq("readdatavalid_idle", 64'(m_readdatavalid), 64'(0));
        end
        if (g >= 0) begin
            if (m_write[g]) begin
                mask = '0;
                for (int b = 0; b < BW; b++) if (be[b]) mask = mask | (DW'(8'hFF) << (8*b));
                if (ref_mem.exists(int'(a)))
                    ref_mem[int'(a)] = (ref_mem[int'(a)] & ~mask) | (d & mask);
                else if (be == '1)
                    ref_mem[int'(a)] = d;
            end else begin
                e.due   = cyc + RL;
                e.id    = g;
                e.known = ref_mem.exists(int'(a));
                e.data  = e.known ? ref_mem[int'(a)] : '0;
                exp_q.push_back(e);
            end
            if (!locked_m) begin
                rr_m = (g + 1) % NM;
                if (m_lock[g]) begin
                    locked_m = 1'b1;
                    owner_m  = g;
                end
            end else if (!m_lock[g]) begin
                locked_m = 1'b0;
                rr_m     = (owner_m + 1) % NM;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        idle_all();
        for (int k = 0; k < RL + 1; k++) step();
    endtask

    initial begin
        reset_n      = 1'b0;
        m_address    = '0;
        m_byteenable = '0;
        m_writedata  = '0;
        m_write      = '0;
        m_lock       = '0;
        m_read       = '1;
        @(negedge clk);
        #1;
        check_eq("rst_waitrequest", 64'(m_waitrequest), 64'(3'b111));
        check_eq("rst_readdatavalid", 64'(m_readdatavalid), 64'(0));
        check_eq("rst_clken", 64'(mem_clken), 64'(0));
        check_eq("rst_chipselect", 64'(mem_chipselect), 64'(0));

        // All three masters reading continuously from reset.
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < NM; i++) set_m(i, 1'b1, 1'b0, 1'b0, AW'(i), '0, '1);
        #1;
        check_eq("clken_run", 64'(mem_clken), 64'(1));
        check_eq("first_grant_m0", 64'(m_waitrequest), 64'(3'b110));
        for (int k = 0; k < 6; k++) step();
        drain();

        // Write then read back on master 1.
        set_m(1, 1'b0, 1'b1, 1'b0, 13'h0010, 32'hDEADBEEF, 4'hF);
        step();
        set_m(1, 1'b1, 1'b0, 1'b0, 13'h0010, '0, 4'hF);
        step();
        idle_all();
        #1;
        check_eq("t2_rdv", 64'(m_readdatavalid), 64'(3'b010));
        check_eq("t2_data", 64'(m_readdata), 64'(32'hDEADBEEF));
        step();
        drain();

        // Byte-lane write over an existing word.
        set_m(0, 1'b0, 1'b1, 1'b0, 13'h0020, 32'h11223344, 4'hF);
        step();
        set_m(0, 1'b0, 1'b1, 1'b0, 13'h0020, 32'h0000AB00, 4'b0010);
        step();
        set_m(0, 1'b1, 1'b0, 1'b0, 13'h0020, '0, 4'hF);
        step();
        idle_all();
        #1;
        check_eq("t5_data", 64'(m_readdata), 64'(32'h1122AB44));
        step();
        drain();

        // Lock held by master 2 for a read-modify-write while master 0 waits.
        set_m(1, 1'b1, 1'b0, 1'b0, 13'h0001, '0, 4'hF);
        step();
        idle_all();
        set_m(0, 1'b1, 1'b0, 1'b0, 13'h0002, '0, 4'hF);
        set_m(2, 1'b1, 1'b0, 1'b1, 13'h0010, '0, 4'hF);
        step();
        set_m(2, 1'b0, 1'b1, 1'b0, 13'h0010, 32'hCAFEF00D, 4'hF);
        step();
        m_read[2]  = 1'b0;
        m_write[2] = 1'b0;
        set_m(1, 1'b1, 1'b0, 1'b0, 13'h0003, '0, 4'hF);
        #1;
        check_eq("t4_m0_after_unlock", 64'(m_waitrequest), 64'(3'b110));
        step();
        drain();

        // Known contents for the random address window.
        for (int a = 0; a < 16; a++) begin
            idle_all();
            set_m(0, 1'b0, 1'b1, 1'b0, AW'(a), $urandom, 4'hF);
            step();
        end

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NM; i++) begin
                int kind;
                kind = $urandom_range(0, 3);
                set_m(i, kind[0], kind[1], ($urandom_range(0, 7) == 0),
                      AW'($urandom_range(0, 15)), $urandom, BW'($urandom_range(0, 15)));
            end
            step();
        end
        // Let any lock owner release before the reset scenario.
        idle_all();
        for (int i = 0; i < NM; i++) set_m(i, 1'b0, 1'b1, 1'b0, 13'h0100, 32'h0, 4'hF);
        for (int k = 0; k < NM + 1; k++) step();
        drain();

        // Reset pulse right after a locked read is accepted.
        set_m(1, 1'b1, 1'b0, 1'b1, 13'h0005, '0, 4'hF);
        step();
        reset_n = 1'b0;
        idle_all();
        #1;
        check_eq("t6_rdv_in_reset", 64'(m_readdatavalid), 64'(0));
        check_eq("t6_wait_in_reset", 64'(m_waitrequest), 64'(3'b111));
        check_eq("t6_clken_in_reset", 64'(mem_clken), 64'(0));
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < NM; i++) set_m(i, 1'b1, 1'b0, 1'b0, AW'(i), '0, 4'hF);
        #1;
        check_eq("t6_rr_zero", 64'(m_waitrequest), 64'(3'b110));
        step();
        drain();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
